// File: rtl/zero_run_win_ctrl.sv
// zero_run_win_ctrl: windowed controller for the serial zero-run detector.
// Arms on start, samples `in` for win_len cycles, counts overlapping runs of
// RUN_LEN zeros, optionally stops early at max_hits, and pulses done once.
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-low reset
//   start        - arm request (IDLE only); win_len/max_hits latched here
//   abort        - cancel open window without done
//   win_len      - samples per window (0 = immediate done)
//   max_hits     - early-stop hit limit (0 = none)
//   in           - serial data bit
//   busy, done   - window open / one-cycle completion pulse
//   hit, hit_cnt - registered per-hit flag and saturating hit count
//   ovf          - sticky: a hit arrived while hit_cnt was all-ones
module zero_run_win_ctrl #(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned WIN_W   = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [CNT_W-1:0] max_hits,
    input  logic             in,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             ovf
);

    localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [RUN_W-1:0]   run_cnt, run_cnt_d;
    logic [WIN_W-1:0]   win_cnt, win_cnt_d;
    logic [WIN_W-1:0]   win_len_q, win_len_d;
    logic [CNT_W-1:0]   max_hits_q, max_hits_d;
    logic [CNT_W-1:0]   hit_cnt_d, hit_cnt_inc;
    logic               hit_d, ovf_d, busy_d, done_d;
    logic               sample_hit, last_sample, early_stop, cnt_full;

    // Sample-level decodes used by the RUN branch
    always_comb begin
        cnt_full    = &hit_cnt;
        hit_cnt_inc = cnt_full ? hit_cnt : hit_cnt + CNT_W'(1);
        // run_cnt already holds RUN_LEN-1 zeros: this zero completes a run
        sample_hit  = (state == RUN) && !abort && !in
                      && (run_cnt >= RUN_W'(RUN_LEN - 1));
        last_sample = (win_cnt == win_len_q - WIN_W'(1));
        early_stop  = sample_hit && (max_hits_q != '0)
                      && (hit_cnt_inc == max_hits_q);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        run_cnt_d  = run_cnt;
        win_cnt_d  = win_cnt;
        win_len_d  = win_len_q;
        max_hits_d = max_hits_q;
        hit_cnt_d  = hit_cnt;
        ovf_d      = ovf;
        hit_d      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    win_len_d  = win_len;
                    max_hits_d = max_hits;
                    hit_cnt_d  = '0;
                    ovf_d      = 1'b0;
                    run_cnt_d  = '0;
                    win_cnt_d  = '0;
                    state_d    = (win_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    win_cnt_d = win_cnt + WIN_W'(1);
                    if (in) begin
                        run_cnt_d = '0;
                    end else if (run_cnt != RUN_W'(RUN_LEN)) begin
                        run_cnt_d = run_cnt + RUN_W'(1);
                    end
                    if (sample_hit) begin
                        hit_d     = 1'b1;
                        hit_cnt_d = hit_cnt_inc;
                        if (cnt_full) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (early_stop || last_sample) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            run_cnt    <= '0;
            win_cnt    <= '0;
            win_len_q  <= '0;
            max_hits_q <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hit        <= 1'b0;
            hit_cnt    <= '0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_d;
            run_cnt    <= run_cnt_d;
            win_cnt    <= win_cnt_d;
            win_len_q  <= win_len_d;
            max_hits_q <= max_hits_d;
            busy       <= busy_d;
            done       <= done_d;
            hit        <= hit_d;
            hit_cnt    <= hit_cnt_d;
            ovf        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_zero_run_win_ctrl.sv
// Bench for zero_run_win_ctrl: directed test-plan windows plus randomized
// windows checked cycle by cycle against a sliding zero-run reference model.
module tb_zero_run_win_ctrl;

    localparam int unsigned RUN_LEN = 4;
    localparam int unsigned WIN_W   = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] max_hits;
    logic             din;
    logic             busy;
    logic             done;
    logic             hit;
    logic [CNT_W-1:0] hit_cnt;
    logic             ovf;

    int errors;
    int checks;
    bit bits [1:255];

    zero_run_win_ctrl #(
        .RUN_LEN(RUN_LEN),
        .WIN_W  (WIN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .win_len (win_len),
        .max_hits(max_hits),
        .in      (din),
        .busy    (busy),
        .done    (done),
        .hit     (hit),
        .hit_cnt (hit_cnt),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one window starting at the current negedge. The model decides a
    // hit when the last RUN_LEN in-window samples were all zero.
    task automatic run_window(input int wl, input int mh, input int abort_at,
                              input int poke, input bit start_in_done);
        int zeros;
        int cnt;
        bit ovf_m;
        bit ex_hit;
        bit ended;
        start    = 1'b1;
        abort    = 1'b0;
        win_len  = WIN_W'(wl);
        max_hits = CNT_W'(mh);
        din      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== (wl != 0) || done !== (wl == 0) || hit !== 1'b0
            || hit_cnt !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL start_edge wl=%0d: busy=%b done=%b hit=%b cnt=%0d ovf=%b, want busy=%b done=%b hit=0 cnt=0 ovf=0",
                     wl, busy, done, hit, hit_cnt, ovf, wl != 0, wl == 0);
        end
        zeros = 0;
        cnt   = 0;
        ovf_m = 1'b0;
        ended = (wl == 0);
        for (int k = 1; k <= wl && !ended; k++) begin
            din   = bits[k];
            abort = (k == abort_at);
            if (k == poke) begin
                start   = 1'b1;
                win_len = WIN_W'(wl + 5);
            end
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (k == abort_at) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0
                    || hit_cnt !== CNT_W'(cnt) || ovf !== ovf_m) begin
                    errors++;
                    $display("FAIL abort k=%0d: busy=%b done=%b hit=%b cnt=%0d ovf=%b, want 0 0 0 cnt=%0d ovf=%b",
                             k, busy, done, hit, hit_cnt, ovf, cnt, ovf_m);
                end
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || hit_cnt !== CNT_W'(cnt)) begin
                    errors++;
                    $display("FAIL abort_after k=%0d: busy=%b done=%b cnt=%0d, want 0 0 cnt=%0d",
                             k, busy, done, hit_cnt, cnt);
                end
                return;
            end
            zeros  = bits[k] ? 0 : zeros + 1;
            ex_hit = (zeros >= RUN_LEN);
            if (ex_hit) begin
                if (cnt == CMAX) ovf_m = 1'b1;
                else             cnt++;
            end
            ended = (k == wl) || (ex_hit && mh != 0 && cnt == mh);
            checks++;
            if (hit !== ex_hit || hit_cnt !== CNT_W'(cnt) || ovf !== ovf_m
                || busy !== !ended || done !== ended) begin
                errors++;
                $display("FAIL sample k=%0d wl=%0d mh=%0d: hit=%b cnt=%0d ovf=%b busy=%b done=%b, want %b %0d %b %b %b",
                         k, wl, mh, hit, hit_cnt, ovf, busy, done,
                         ex_hit, cnt, ovf_m, !ended, ended);
            end
        end
        // Currently in the DONE cycle; start here must be ignored
        if (start_in_done) begin
            start   = 1'b1;
            win_len = WIN_W'(5);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0
            || hit_cnt !== CNT_W'(cnt) || ovf !== ovf_m) begin
            errors++;
            $display("FAIL post_done wl=%0d: busy=%b done=%b hit=%b cnt=%0d ovf=%b, want 0 0 0 %0d %b",
                     wl, busy, done, hit, hit_cnt, ovf, cnt, ovf_m);
        end
    endtask

    task automatic fill_bits(input int ones_every);
        for (int i = 1; i <= 255; i++) begin
            bits[i] = (ones_every == 0) ? 1'b0 : ($urandom_range(0, ones_every - 1) == 0);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        win_len  = '0;
        max_hits = '0;
        din      = 1'b1;
        #2;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || hit_cnt !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hit=%b cnt=%0d ovf=%b, want all 0",
                     busy, done, hit, hit_cnt, ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_plan();
        // 0,0,0,0,0,0,1,0,0,0 -> hits at samples 4,5,6
        for (int i = 1; i <= 255; i++) bits[i] = 1'b0;
        bits[7] = 1'b1;
        run_window(10, 0, 0, 0, 1'b0);
        // early stop at two hits
        fill_bits(0);
        run_window(20, 2, 0, 0, 1'b0);
        // zero-length window
        run_window(0, 0, 0, 0, 1'b0);
        // start poked mid-window is ignored
        fill_bits(3);
        run_window(10, 0, 0, 3, 1'b0);
        // saturation and overflow
        fill_bits(0);
        run_window(25, 0, 0, 0, 1'b0);
        // early stop at the all-ones limit
        run_window(30, CMAX, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        fill_bits(0);
        run_window(20, 0, 7, 0, 1'b0);
        // abort on the final sample wins over done
        run_window(8, 0, 8, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_bits(2);
        run_window(6, 0, 0, 0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: busy=%b, want 0", busy);
        end
        fill_bits(0);
        run_window(9, 0, 0, 0, 1'b0);
        run_window(12, 3, 0, 0, 1'b0);
        run_window(0, 0, 0, 0, 1'b0);
        run_window(5, 0, 0, 0, 1'b0);
    endtask

    task automatic test_midreset();
        fill_bits(0);
        start    = 1'b1;
        win_len  = WIN_W'(20);
        max_hits = '0;
        din      = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit !== 1'b0 || hit_cnt !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL midreset: busy=%b done=%b hit=%b cnt=%0d ovf=%b, want all 0",
                     busy, done, hit, hit_cnt, ovf);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hit_cnt !== '0) begin
            errors++;
            $display("FAIL after_reset: busy=%b done=%b cnt=%0d, want 0 0 0", busy, done, hit_cnt);
        end
        // clean window: runs must not carry over from before reset
        for (int i = 1; i <= 255; i++) bits[i] = 1'b0;
        bits[1] = 1'b1;
        run_window(8, 0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        int wl;
        int mh;
        int ab;
        for (int n = 0; n < 40; n++) begin
            fill_bits(int'($urandom_range(2, 5)));
            wl = int'($urandom_range(0, 40));
            mh = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, CMAX));
            ab = (wl != 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, wl)) : 0;
            run_window(wl, mh, ab, 0, 1'b0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_plan();
        test_abort();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
